mw_countdown_timer: RTL and testbench

- Cooking-time countdown for the microwave controller.
- Accepts keypad BCD digits into an MM:SS register and counts down once per second while the magnetron runs (mag_on=1).
- Drives timer_done back to the magnetron on/off control logic.
- Sits beside the magnetron control block: consumes its mag_on output and produces its timer_done input.

---
 rtl/mw_countdown_timer_pkg.sv | 23 ++
 rtl/mw_tick_gen.sv | 27 ++
 rtl/mw_countdown_timer.sv | 135 +++++++++++++
 tb/tb_mw_countdown_timer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_countdown_timer_pkg.sv
// Shared encodings and the MM:SS payload for the microwave countdown timer.
package mw_countdown_timer_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
   localparam logic [DIGIT_W-1:0] SEC_TENS_WRAP = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_RUNNING = 2'b10,
      ST_PAUSED  = 2'b11
   } state_t;

   typedef struct packed {
      logic [DIGIT_W-1:0] min_tens;
      logic [DIGIT_W-1:0] min_ones;
      logic [DIGIT_W-1:0] sec_tens;
      logic [DIGIT_W-1:0] sec_ones;
   } bcd_time_t;

endpackage

// File: rtl/mw_tick_gen.sv
// Seconds prescaler: counts while enabled, one-cycle tick on the terminal count.
module mw_tick_gen #(
   parameter int unsigned TICKS_PER_SEC = 100,
   parameter int unsigned PS_W          = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick_c
);

   logic [PS_W-1:0] r_ps;
   logic            w_wrap;

   assign w_wrap   = (r_ps == PS_W'(TICKS_PER_SEC - 1));
   assign o_tick_c = i_en && w_wrap;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_ps <= '0;
      end else if (i_en) begin
         r_ps <= w_wrap ? '0 : r_ps + PS_W'(1);
      end
   end

endmodule

// File: rtl/mw_countdown_timer.sv
// Microwave cooking timer: keypad BCD entry into MM:SS and once-per-second
// countdown while the magnetron runs; timer_done feeds the magnetron control.
module mw_countdown_timer
   import mw_countdown_timer_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 100,
   parameter int unsigned PS_W          = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clearn,
   input  logic               mag_on,
   input  logic               digit_valid,
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] min_tens,
   output logic [DIGIT_W-1:0] min_ones,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic               timer_done,
   output logic [1:0]         state
);

   bcd_time_t r_cnt;
   bcd_time_t w_cnt_nxt;
   state_t    r_state;
   state_t    w_state_nxt;
   logic      r_done;
   logic      w_done_nxt;
   logic      w_tick;
   logic      w_digit_ok;
   logic      w_ps_en;
   logic      w_ps_clr;

   // BCD borrow chain; seconds tens re-enter at 5 so minutes borrow yields :59
   function automatic bcd_time_t bcd_dec(input bcd_time_t t);
      bcd_time_t d;
      d = t;
      if (t.sec_ones != '0) begin
         d.sec_ones = t.sec_ones - DIGIT_W'(1);
      end else if (t.sec_tens != '0) begin
         d.sec_tens = t.sec_tens - DIGIT_W'(1);
         d.sec_ones = BCD_MAX_DIGIT;
      end else if (t.min_ones != '0) begin
         d.min_ones = t.min_ones - DIGIT_W'(1);
         d.sec_tens = SEC_TENS_WRAP;
         d.sec_ones = BCD_MAX_DIGIT;
      end else if (t.min_tens != '0) begin
         d.min_tens = t.min_tens - DIGIT_W'(1);
         d.min_ones = BCD_MAX_DIGIT;
         d.sec_tens = SEC_TENS_WRAP;
         d.sec_ones = BCD_MAX_DIGIT;
      end
      return d;
   endfunction

   assign w_digit_ok = digit_valid && (digit <= BCD_MAX_DIGIT);
   assign w_ps_en    = (r_state == ST_RUNNING);
   // Leaving RUNNING (pause, done, clear) discards the partial second
   assign w_ps_clr   = (w_state_nxt != ST_RUNNING);

   mw_tick_gen #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .PS_W          (PS_W)
   ) u_tick_gen (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_ps_en),
      .i_clr    (w_ps_clr),
      .o_tick_c (w_tick)
   );

   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_state_nxt = r_state;
      if (!clearn) begin
         w_cnt_nxt   = '0;
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_ARMED: begin
               if (w_digit_ok) begin
                  w_cnt_nxt.min_tens = r_cnt.min_ones;
                  w_cnt_nxt.min_ones = r_cnt.sec_tens;
                  w_cnt_nxt.sec_tens = r_cnt.sec_ones;
                  w_cnt_nxt.sec_ones = digit;
               end
               if (w_cnt_nxt == '0) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_state == ST_IDLE) begin
                  w_state_nxt = ST_ARMED;
               end else if (mag_on) begin
                  w_state_nxt = ST_RUNNING;
               end
            end
            ST_RUNNING: begin
               if (w_tick) begin
                  w_cnt_nxt = bcd_dec(r_cnt);
               end
               if (w_cnt_nxt == '0) begin
                  w_state_nxt = ST_IDLE;
               end else if (!mag_on) begin
                  w_state_nxt = ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               if (mag_on) begin
                  w_state_nxt = ST_RUNNING;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
      w_done_nxt = (w_cnt_nxt == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_state <= ST_IDLE;
         r_done  <= 1'b1;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign min_tens   = r_cnt.min_tens;
   assign min_ones   = r_cnt.min_ones;
   assign sec_tens   = r_cnt.sec_tens;
   assign sec_ones   = r_cnt.sec_ones;
   assign timer_done = r_done;
   assign state      = r_state;

endmodule

// File: tb/tb_mw_countdown_timer.sv
// Bench for mw_countdown_timer: vector table, corner sequences, and random
// stimulus checked against a seconds-level behavioural model.
module tb_mw_countdown_timer;

   localparam int unsigned TPS = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       clearn;
   logic       mag_on;
   logic       digit_valid;
   logic [3:0] digit;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       timer_done;
   logic [1:0] state;
   logic [18:0] dut_out;

   int n_cmp = 0;
   int n_bad = 0;

   // model: count as decimal MMSS integer, mode 0..3, cycles spent running
   int m_v  = 0;
   int m_st = 0;
   int m_ph = 0;

   typedef struct {
      logic        rst;
      logic        clrn;
      logic        mag;
      logic        dv;
      logic [3:0]  dg;
      logic [15:0] cnt;
      logic        done;
      logic [1:0]  st;
   } vec_t;

   vec_t vecs[11];

   mw_countdown_timer #(.TICKS_PER_SEC(TPS), .PS_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .clearn      (clearn),
      .mag_on      (mag_on),
      .digit_valid (digit_valid),
      .digit       (digit),
      .min_tens    (min_tens),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .timer_done  (timer_done),
      .state       (state)
   );

   always #5 clk = ~clk;

   assign dut_out = {min_tens, min_ones, sec_tens, sec_ones, timer_done, state};

   function automatic int dec_time(input int v);
      int m, s;
      m = v / 100;
      s = v % 100;
      if (s > 0) s = s - 1;
      else if (m > 0) begin
         m = m - 1;
         s = 59;
      end
      return m * 100 + s;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_edge();
      logic tick;
      if (reset) begin
         m_v = 0; m_st = 0; m_ph = 0;
      end else if (!clearn) begin
         m_v = 0; m_st = 0; m_ph = 0;
      end else begin
         case (m_st)
            0, 1: begin
               if (digit_valid && digit <= 4'd9) m_v = (m_v * 10 + int'(digit)) % 10000;
               if (m_v == 0) m_st = 0;
               else if (m_st == 0) m_st = 1;
               else if (mag_on) m_st = 2;
               m_ph = 0;
            end
            2: begin
               tick = (m_ph == TPS - 1);
               m_ph = tick ? 0 : m_ph + 1;
               if (tick) m_v = dec_time(m_v);
               if (m_v == 0) begin m_st = 0; m_ph = 0; end
               else if (!mag_on) begin m_st = 3; m_ph = 0; end
            end
            default: begin
               if (mag_on) m_st = 2;
               m_ph = 0;
            end
         endcase
      end
   endtask

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got cnt=%h done=%b st=%b, want cnt=%h done=%b st=%b",
                  name, act[18:3], act[2], act[1:0], exp[18:3], exp[2], exp[1:0]);
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic m, input logic v,
                        input logic [3:0] d);
      reset = r; clearn = c; mag_on = m; digit_valid = v; digit = d;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("model", dut_out, {to_bcd(m_v), (m_v == 0), 2'(m_st)});
   endtask

   task automatic expect_now(input string name, input logic [15:0] cnt,
                             input logic done, input logic [1:0] st);
      check(name, dut_out, {cnt, done, st});
   endtask

   // reset, then key in the n low BCD digits of bcd, most significant first
   task automatic fresh(input logic [15:0] bcd, input int n);
      drive(1, 1, 0, 0, 0);
      step();
      for (int i = n - 1; i >= 0; i--) begin
         drive(0, 1, 0, 1, bcd[4*i +: 4]);
         step();
      end
      drive(0, 1, 0, 0, 0);
   endtask

   initial begin
      drive(1, 1, 0, 0, 0);
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 2'b00};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 16'h0001, 1'b0, 2'b01};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 16'h0013, 1'b0, 2'b01};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 16'h0130, 1'b0, 2'b01};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 16'h0130, 1'b0, 2'b01};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 16'h0130, 1'b0, 2'b01};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 16'h0000, 1'b1, 2'b00};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 1'b1, 2'b00};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 16'h0005, 1'b0, 2'b01};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 16'h0050, 1'b0, 2'b01};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0050, 1'b0, 2'b10};

      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].rst, vecs[i].clrn, vecs[i].mag, vecs[i].dv, vecs[i].dg);
         step();
         check($sformatf("vec%0d", i), dut_out, {vecs[i].cnt, vecs[i].done, vecs[i].st});
      end

      // 01:30 full run to zero
      fresh(16'h0130, 3);
      drive(0, 1, 0, 1, 4'hA);
      step();
      expect_now("load_0130", 16'h0130, 1'b0, 2'b01);
      drive(0, 1, 1, 0, 0);
      step();
      expect_now("run_start", 16'h0130, 1'b0, 2'b10);
      repeat (3) step();
      expect_now("pre_tick", 16'h0130, 1'b0, 2'b10);
      step();
      expect_now("first_tick", 16'h0129, 1'b0, 2'b10);
      repeat (89 * TPS) step();
      expect_now("run_done", 16'h0000, 1'b1, 2'b00);
      repeat (5) step();
      expect_now("done_hold", 16'h0000, 1'b1, 2'b00);

      // pause and resume
      fresh(16'h0002, 1);
      drive(0, 1, 1, 0, 0);
      repeat (6) step();
      drive(0, 1, 0, 0, 0);
      step();
      expect_now("paused", 16'h0001, 1'b0, 2'b11);
      drive(0, 1, 0, 1, 4'h7);
      step();
      expect_now("pause_digit", 16'h0001, 1'b0, 2'b11);
      drive(0, 1, 1, 0, 0);
      step();
      expect_now("resume", 16'h0001, 1'b0, 2'b10);
      repeat (TPS) step();
      expect_now("resume_done", 16'h0000, 1'b1, 2'b00);

      // borrow chain boundaries
      fresh(16'h0100, 3);
      drive(0, 1, 1, 0, 0);
      repeat (TPS + 1) step();
      expect_now("borrow_0100", 16'h0059, 1'b0, 2'b10);
      fresh(16'h1000, 4);
      drive(0, 1, 1, 0, 0);
      repeat (TPS + 1) step();
      expect_now("borrow_1000", 16'h0959, 1'b0, 2'b10);
      fresh(16'h0090, 2);
      drive(0, 1, 1, 0, 0);
      repeat (TPS + 1) step();
      expect_now("borrow_0090", 16'h0089, 1'b0, 2'b10);

      // clear wins over a simultaneous digit
      fresh(16'h0005, 1);
      drive(0, 1, 1, 0, 0);
      repeat (2 * TPS + 1) step();
      expect_now("two_ticks", 16'h0003, 1'b0, 2'b10);
      drive(0, 0, 1, 1, 4'h3);
      step();
      expect_now("clear_digit", 16'h0000, 1'b1, 2'b00);

      // mag_on with nothing loaded, then reset mid-run
      drive(1, 1, 0, 0, 0);
      step();
      drive(0, 1, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         expect_now("idle_mag", 16'h0000, 1'b1, 2'b00);
      end
      drive(0, 1, 1, 1, 4'h3);
      step();
      expect_now("idle_load", 16'h0003, 1'b0, 2'b01);
      drive(0, 1, 1, 0, 0);
      repeat (3) step();
      expect_now("mid_run", 16'h0003, 1'b0, 2'b10);
      drive(1, 1, 1, 0, 0);
      step();
      expect_now("reset_mid", 16'h0000, 1'b1, 2'b00);

      // randomized traffic against the model
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         reset       = ($urandom_range(199) == 0);
         clearn      = ($urandom_range(59) != 0);
         if ($urandom_range(24) == 0) mag_on = ~mag_on;
         digit_valid = ($urandom_range(3) == 0);
         digit       = 4'($urandom_range(15));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
